// File: rtl/pipe_stage_reg.sv
// Flow-controlled pipeline stage register with flush and bubble zeroing.
// Define PIPE_STAGE_SKID_EN for the two-entry skid buffer with a registered in_ready.
module pipe_stage_reg #(
    parameter int unsigned DATA_W = 64,
    parameter int unsigned CTRL_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [1:0]        occ
);

`ifdef PIPE_STAGE_SKID_EN
    typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} state_t;

    state_t            state_q, state_d;
    logic              in_ready_q, in_ready_d;
    logic [DATA_W-1:0] m_data_q, m_data_d, s_data_q, s_data_d;
    logic [CTRL_W-1:0] m_ctrl_q, m_ctrl_d, s_ctrl_q, s_ctrl_d;
    logic              in_xfer, out_xfer;

    assign in_xfer  = in_valid & in_ready_q;
    assign out_xfer = (state_q != EMPTY) & out_ready;

    always_comb begin
        state_d  = state_q;
        m_data_d = m_data_q;
        m_ctrl_d = m_ctrl_q;
        s_data_d = s_data_q;
        s_ctrl_d = s_ctrl_q;
        case (state_q)
            EMPTY: begin
                if (in_xfer) begin
                    m_data_d = in_data;
                    m_ctrl_d = in_ctrl;
                    state_d  = ONE;
                end
            end
            ONE: begin
                if (in_xfer && out_xfer) begin
                    m_data_d = in_data;
                    m_ctrl_d = in_ctrl;
                end else if (in_xfer) begin
                    s_data_d = in_data;
                    s_ctrl_d = in_ctrl;
                    state_d  = FULL;
                end else if (out_xfer) begin
                    m_data_d = '0;
                    m_ctrl_d = '0;
                    state_d  = EMPTY;
                end
            end
            FULL: begin
                if (out_xfer) begin
                    m_data_d = s_data_q;
                    m_ctrl_d = s_ctrl_q;
                    s_data_d = '0;
                    s_ctrl_d = '0;
                    state_d  = ONE;
                end
            end
            default: begin
                m_data_d = '0;
                m_ctrl_d = '0;
                s_data_d = '0;
                s_ctrl_d = '0;
                state_d  = EMPTY;
            end
        endcase
        if (flush) begin
            m_data_d = '0;
            m_ctrl_d = '0;
            s_data_d = '0;
            s_ctrl_d = '0;
            state_d  = EMPTY;
        end
        // Ready is computed from next state so it leaves a flop with no out_ready path.
        in_ready_d = (state_d != FULL);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= EMPTY;
            in_ready_q <= 1'b1;
            m_data_q   <= '0;
            m_ctrl_q   <= '0;
            s_data_q   <= '0;
            s_ctrl_q   <= '0;
        end else begin
            state_q    <= state_d;
            in_ready_q <= in_ready_d;
            m_data_q   <= m_data_d;
            m_ctrl_q   <= m_ctrl_d;
            s_data_q   <= s_data_d;
            s_ctrl_q   <= s_ctrl_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = (state_q != EMPTY);
    assign out_data  = m_data_q;
    assign out_ctrl  = m_ctrl_q;
    assign occ       = (state_q == FULL) ? 2'd2 : ((state_q == ONE) ? 2'd1 : 2'd0);
`else
    logic              m_valid_q, m_valid_d;
    logic [DATA_W-1:0] m_data_q, m_data_d;
    logic [CTRL_W-1:0] m_ctrl_q, m_ctrl_d;
    logic              in_xfer, out_xfer;

    assign in_ready = !m_valid_q | out_ready;
    assign in_xfer  = in_valid & in_ready;
    assign out_xfer = m_valid_q & out_ready;

    always_comb begin
        m_valid_d = m_valid_q;
        m_data_d  = m_data_q;
        m_ctrl_d  = m_ctrl_q;
        if (flush) begin
            m_valid_d = 1'b0;
            m_data_d  = '0;
            m_ctrl_d  = '0;
        end else if (in_xfer) begin
            m_valid_d = 1'b1;
            m_data_d  = in_data;
            m_ctrl_d  = in_ctrl;
        end else if (out_xfer) begin
            m_valid_d = 1'b0;
            m_data_d  = '0;
            m_ctrl_d  = '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_valid_q <= 1'b0;
            m_data_q  <= '0;
            m_ctrl_q  <= '0;
        end else begin
            m_valid_q <= m_valid_d;
            m_data_q  <= m_data_d;
            m_ctrl_q  <= m_ctrl_d;
        end
    end

    assign out_valid = m_valid_q;
    assign out_data  = m_data_q;
    assign out_ctrl  = m_ctrl_q;
    assign occ       = {1'b0, m_valid_q};
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg: FIFO scoreboard plus occupancy/ready model,
// valid for both the default build and the PIPE_STAGE_SKID_EN build.
module tb_pipe_stage_reg;
    localparam int unsigned DW = 64;
    localparam int unsigned CW = 16;

    typedef struct packed {
        logic [DW-1:0] d;
        logic [CW-1:0] c;
    } beat_t;

    logic          clk;
    logic          reset;
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic [CW-1:0] in_ctrl;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic [CW-1:0] out_ctrl;
    logic [1:0]    occ;

    pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW)) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_ctrl   (in_ctrl),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_ctrl  (out_ctrl),
        .occ       (occ)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    beat_t sb[$];
    beat_t src[$];
    int    errors = 0;
    int    checks = 0;
    logic  rst_req = 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: drive at negedge, check just after, then advance the model across the posedge.
    task automatic cycle(input logic iv, input logic [DW-1:0] d, input logic [CW-1:0] c,
                         input logic ordy, input logic fl, output logic acc);
        logic  exp_rdy;
        logic  exp_ov;
        beat_t b;
        @(negedge clk);
        reset     = rst_req;
        in_valid  = iv;
        in_data   = d;
        in_ctrl   = c;
        out_ready = ordy;
        flush     = fl;
        #1;
`ifdef PIPE_STAGE_SKID_EN
        exp_rdy = (sb.size() < 2);
`else
        exp_rdy = (sb.size() == 0) || ordy;
`endif
        exp_ov = (sb.size() > 0);
        chk("in_ready", 64'(in_ready), 64'(exp_rdy));
        chk("out_valid", 64'(out_valid), 64'(exp_ov));
        chk("occ", 64'(occ), 64'(sb.size()));
        chk("out_data", out_data, exp_ov ? sb[0].d : 64'd0);
        chk("out_ctrl", 64'(out_ctrl), exp_ov ? 64'(sb[0].c) : 64'd0);
        acc = reset && iv && exp_rdy;
        if (!reset || fl) begin
            sb.delete();
        end else begin
            if (exp_ov && ordy) void'(sb.pop_front());
            if (acc) begin
                b.d = d;
                b.c = c;
                sb.push_back(b);
            end
        end
    endtask

    task automatic drive_src(input int ncyc, input logic ordy);
        logic acc;
        for (int i = 0; i < ncyc; i++) begin
            if (src.size() > 0) cycle(1'b1, src[0].d, src[0].c, ordy, 1'b0, acc);
            else                cycle(1'b0, '0, '0, ordy, 1'b0, acc);
            if (acc && src.size() > 0) void'(src.pop_front());
        end
    endtask

    task automatic add_src(input logic [DW-1:0] d, input logic [CW-1:0] c);
        beat_t b;
        b.d = d;
        b.c = c;
        src.push_back(b);
    endtask

    initial begin
        logic acc;
        reset     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_ctrl   = '0;
        out_ready = 1'b0;

        // Reset held for 3 cycles with handshakes offered; all must be ignored.
        rst_req = 1'b0;
        for (int i = 0; i < 3; i++) cycle(1'b1, 64'h77, 16'h77, 1'b1, 1'b0, acc);
        rst_req = 1'b1;

        // Pass-through stream 1..8.
        for (int i = 1; i <= 8; i++) add_src(64'(i), 16'(i) ^ 16'h5A5A);
        drive_src(11, 1'b1);

        // Stall fill with A, B, C then release.
        add_src(64'hA, 16'h00A0);
        add_src(64'hB, 16'h00B0);
        add_src(64'hC, 16'h00C0);
        drive_src(4, 1'b0);
        drive_src(6, 1'b1);

        // Flush with full control strobes held and a concurrent input beat.
        add_src(64'h1111, 16'hFFFF);
        add_src(64'h2222, 16'hFFFF);
        drive_src(3, 1'b0);
        cycle(1'b1, 64'hDEAD, 16'hFFFF, 1'b0, 1'b1, acc);
        src.delete();
        drive_src(3, 1'b1);

        // Simultaneous in/out for 10 cycles.
        for (int i = 0; i < 10; i++) add_src(64'h100 + 64'(i), 16'h0100 + 16'(i));
        drive_src(12, 1'b1);

        // Random traffic with occasional flush.
        for (int i = 0; i < 120; i++) begin
            cycle(1'($urandom_range(0, 3) != 0), {$urandom, $urandom}, 16'($urandom),
                  1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 15) == 0), acc);
        end
        drive_src(3, 1'b1);

        // Async reset mid-stall, asserted between edges.
        add_src(64'hAAA1, 16'h1234);
        add_src(64'hAAA2, 16'h4321);
        drive_src(3, 1'b0);
        @(negedge clk);
        #2;
        reset   = 1'b0;
        rst_req = 1'b0;
        #1;
        chk("async_out_valid", 64'(out_valid), 64'd0);
        chk("async_occ", 64'(occ), 64'd0);
        chk("async_out_data", out_data, 64'd0);
        chk("async_out_ctrl", 64'(out_ctrl), 64'd0);
        sb.delete();
        src.delete();
        drive_src(2, 1'b0);
        rst_req = 1'b1;

        // First transfer after release.
        add_src(64'hBEEF, 16'h0F0F);
        add_src(64'hCAFE, 16'hF0F0);
        drive_src(5, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
